// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage pipeline.
// Optional event counters (stall_cnt, fwd_cnt) are built only when HAZ_STATS_EN is defined.
module hazard_forward_ctrl #(
    parameter int REG_AW             = 5,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_wen,
    input  logic              dec_load,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
`ifdef HAZ_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt,
`endif
    output logic              stall
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b10;
    localparam logic [1:0] SEL_MWB = 2'b01;

    logic [REG_AW-1:0] ex_rd;
    logic              ex_wen;
    logic              ex_load;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_wen;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic kill;
    logic [1:0] a_nxt, b_nxt;

    // Register 0 is excluded so writes to it never forward and never stall.
    function automatic logic reg_match(input logic              wen,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] r);
        return wen && (rd == r) && !((ZERO_REG_HARDWIRED != 0) && (r == '0));
    endfunction

    always_comb begin
        ex_hit_rs  = reg_match(ex_wen, ex_rd, dec_rs);
        ex_hit_rt  = reg_match(ex_wen, ex_rd, dec_rt);
        mem_hit_rs = reg_match(mem_wen, mem_rd, dec_rs);
        mem_hit_rt = reg_match(mem_wen, mem_rd, dec_rt);

        stall = dec_valid && !flush && ex_load && (ex_hit_rs || ex_hit_rt);
        kill  = flush || stall || !dec_valid;

        // The younger EX result takes priority over the MEM result.
        a_nxt = ex_hit_rs ? SEL_EXM : (mem_hit_rs ? SEL_MWB : SEL_RF);
        b_nxt = ex_hit_rt ? SEL_EXM : (mem_hit_rt ? SEL_MWB : SEL_RF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd     <= '0;
            ex_wen    <= 1'b0;
            ex_load   <= 1'b0;
            mem_rd    <= '0;
            mem_wen   <= 1'b0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else begin
            mem_rd  <= ex_rd;
            mem_wen <= ex_wen;
            if (kill) begin
                ex_rd     <= '0;
                ex_wen    <= 1'b0;
                ex_load   <= 1'b0;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end else begin
                ex_rd     <= dec_rd;
                ex_wen    <= dec_wen;
                ex_load   <= dec_load;
                fwd_a_sel <= a_nxt;
                fwd_b_sel <= b_nxt;
            end
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (!kill && ((a_nxt != SEL_RF) || (b_nxt != SEL_RF)))
                fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`endif

endmodule
